// File: rtl/window_filter_engine.sv
// Streaming 3x3 median/Gaussian window filter over an IMG_DIM x IMG_DIM raster frame.
// Keeps two line buffers and a 3x3 window; emits (IMG_DIM-2)^2 interior results with backpressure.
module window_filter_engine #(
  parameter int IMG_DIM    = 21,
  parameter int BIT_LENGTH = 5,
  parameter int IDX_W      = $clog2(IMG_DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH-1:0] in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_LENGTH-1:0] out_pixel,
  output logic [IDX_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done
);

  localparam int B  = BIT_LENGTH;
  localparam int SW = BIT_LENGTH + 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_DIM - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(IMG_DIM - 2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  // Window element k = 3*r + c; r = 0 is the oldest row, c = 0 the oldest column.
  function automatic logic [B-1:0] median9(input logic [9*B-1:0] w);
    logic [B-1:0] p [0:8];
    logic [3:0]   rank;
    logic [B-1:0] res;
    res = {B{1'b0}};
    for (int i = 0; i < 9; i++) p[i] = w[i*B +: B];
    for (int i = 0; i < 9; i++) begin
      rank = 4'd0;
      for (int j = 0; j < 9; j++) begin
        if ((j != i) && ((p[j] < p[i]) || ((p[j] == p[i]) && (j < i)))) rank = rank + 4'd1;
        else rank = rank;
      end
      if (rank == 4'd4) res = p[i];
      else res = res;
    end
    return res;
  endfunction

  function automatic logic [B-1:0] gauss9(input logic [9*B-1:0] w);
    logic [SW-1:0] s;
    logic [SW-1:0] t;
    s = {SW{1'b0}};
    for (int k = 0; k < 9; k++) begin
      t = {4'b0000, w[k*B +: B]};
      if (k == 4) s = s + (t << 2);
      else if ((k % 2) == 1) s = s + (t << 1);
      else s = s + t;
    end
    s = s + SW'(8);
    return s[B+3:4];
  endfunction

  state_t           state_q, state_d;
  logic             mode_q, mode_d, last_q, last_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [9*B-1:0]   win_q, win_d, win_next_s;
  logic [B-1:0]     lb1_q [0:IMG_DIM-1];
  logic [B-1:0]     lb1_d [0:IMG_DIM-1];
  logic [B-1:0]     lb2_q [0:IMG_DIM-1];
  logic [B-1:0]     lb2_d [0:IMG_DIM-1];
  logic             out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic [B-1:0]     out_pixel_q, out_pixel_d, result_s;
  logic [IDX_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic             accept_s, qual_s, out_hs_s, last_out_s;

  assign in_ready   = (state_q == S_RUN) && !last_q && (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready;
  assign qual_s     = (row_q >= IDX_W'(2)) && (col_q >= IDX_W'(2));
  assign out_hs_s   = out_valid_q && out_ready;
  assign last_out_s = out_hs_s && (out_row_q == END_IDX) && (out_col_q == END_IDX);
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Shifted window including the incoming column, and the filter result on it.
  always_comb begin
    win_next_s = win_q;
    for (int r = 0; r < 3; r++) begin
      win_next_s[(3*r)*B +: B]   = win_q[(3*r+1)*B +: B];
      win_next_s[(3*r+1)*B +: B] = win_q[(3*r+2)*B +: B];
    end
    win_next_s[2*B +: B] = lb2_q[col_q];
    win_next_s[5*B +: B] = lb1_q[col_q];
    win_next_s[8*B +: B] = in_pixel;
    if (mode_q) result_s = gauss9(win_next_s);
    else result_s = median9(win_next_s);
  end

  // Next-state logic for control, indices, buffers and the output register.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    last_d      = last_q;
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    lb1_d       = lb1_q;
    lb2_d       = lb2_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          last_d  = 1'b0;
          row_d   = {IDX_W{1'b0}};
          col_d   = {IDX_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          win_d        = win_next_s;
          lb2_d[col_q] = lb1_q[col_q];
          lb1_d[col_q] = in_pixel;
          if (col_q == LAST_IDX) begin
            col_d = {IDX_W{1'b0}};
            if (row_q == LAST_IDX) begin
              row_d  = {IDX_W{1'b0}};
              last_d = 1'b1;
            end else begin
              row_d = row_q + IDX_W'(1);
            end
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end else begin
          win_d = win_q;
        end
        // A new result may replace the one handed off in the same cycle.
        if (accept_s && qual_s) begin
          out_valid_d = 1'b1;
          out_pixel_d = result_s;
          out_row_d   = row_q - IDX_W'(1);
          out_col_d   = col_q - IDX_W'(1);
        end else if (out_hs_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        if (last_out_s) state_d = S_DONE;
        else state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      last_q      <= 1'b0;
      row_q       <= {IDX_W{1'b0}};
      col_q       <= {IDX_W{1'b0}};
      win_q       <= {(9*B){1'b0}};
      for (int i = 0; i < IMG_DIM; i++) begin
        lb1_q[i] <= {B{1'b0}};
        lb2_q[i] <= {B{1'b0}};
      end
      out_valid_q <= 1'b0;
      out_pixel_q <= {B{1'b0}};
      out_row_q   <= {IDX_W{1'b0}};
      out_col_q   <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      lb1_q       <= lb1_d;
      lb2_q       <= lb2_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule
